// File: rtl/apb_req_scheduler.sv
// rtl/apb_req_scheduler.sv - shares one APB master port between NUM_REQ requesters with arbitration and bus-hang timeout
module apb_req_scheduler #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 16
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic [ADDR_W-1:0]           PADDR,
    output logic [DATA_W-1:0]           PWDATA,
    output logic                        PWRITE,
    output logic                        PSEL,
    output logic                        PENABLE,
    input  logic [DATA_W-1:0]           PRDATA,
    input  logic                        PREADY,
    input  logic                        PSLVERR
);

    localparam int GID_W = $clog2(NUM_REQ);
    // Counter is wide enough to hold TIMEOUT; a 1-bit stub when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t             state;
    state_t             state_nx;
    logic [GID_W-1:0]   rr_ptr;
    logic [GID_W-1:0]   win_idx;
    logic               win_found;
    logic [CNT_W-1:0]   to_cnt;
    logic               to_hit;
    logic               accept;
    logic               done_ok;

    // The ACCESS cycle that would push the counter to TIMEOUT with PREADY still low ends the transfer.
    assign to_hit  = (TIMEOUT != 0) && (state == S_ACCESS) && !PREADY && (to_cnt == TO_LAST);
    assign accept  = (state == S_IDLE) && win_found;
    assign done_ok = (state == S_ACCESS) && PREADY;

    // Winner selection: rotating search from rr_ptr+1, or lowest asserted index in fixed mode.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    win_found = 1'b1;
                    win_idx   = GID_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (!win_found && req_valid[idx]) begin
                    win_found = 1'b1;
                    win_idx   = GID_W'(idx);
                end
            end
        end
    end

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: IDLE -> SETUP on a grant, one SETUP cycle, ACCESS until PREADY or timeout.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (win_found) state_nx = S_SETUP;
            S_SETUP:  state_nx = S_ACCESS;
            S_ACCESS: if (PREADY || to_hit) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state; the accept strobe only exists in IDLE.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
        PSEL    = (state != S_IDLE);
        PENABLE = (state == S_ACCESS);
        busy    = (state != S_IDLE);
    end

    // Transfer datapath: capture on accept, count wait states, post the response on completion.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            grant_id  <= '0;
            rr_ptr    <= GID_W'(NUM_REQ - 1);
            to_cnt    <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            if (accept) begin
                PADDR    <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                PWDATA   <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                PWRITE   <= req_write[win_idx];
                grant_id <= win_idx;
                to_cnt   <= '0;
                if (ARB_MODE == 0) begin
                    rr_ptr <= win_idx;
                end
            end
            if (state == S_ACCESS && !PREADY && to_cnt != '1) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (done_ok) begin
                rsp_valid <= NUM_REQ'(1) << grant_id;
                rsp_err   <= PSLVERR;
                rsp_rdata <= PWRITE ? '0 : PRDATA;
            end else if (to_hit) begin
                rsp_valid <= NUM_REQ'(1) << grant_id;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_req_scheduler.sv
// tb/tb_apb_req_scheduler.sv - scoreboard bench for apb_req_scheduler with directed vectors
module tb_apb_req_scheduler;

    logic        HCLK;
    logic        HRESETn;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [0:0]  grant_id;
    logic        busy;
    logic [31:0] PADDR, PWDATA;
    logic        PWRITE, PSEL, PENABLE;

    logic [1:0]  req_ready_f, rsp_valid_f;
    logic [31:0] rsp_rdata_f;
    logic        rsp_err_f;
    logic [0:0]  grant_id_f;
    logic        busy_f;
    logic [31:0] PADDR_f, PWDATA_f;
    logic        PWRITE_f, PSEL_f, PENABLE_f;

    apb_req_scheduler #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .grant_id(grant_id), .busy(busy),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_req_scheduler #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(4)) dut_fixed (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready_f), .rsp_valid(rsp_valid_f), .rsp_rdata(rsp_rdata_f), .rsp_err(rsp_err_f),
        .grant_id(grant_id_f), .busy(busy_f),
        .PADDR(PADDR_f), .PWDATA(PWDATA_f), .PWRITE(PWRITE_f), .PSEL(PSEL_f), .PENABLE(PENABLE_f),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        int          id;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t sbq[$];

    logic        exp_psel, exp_pen, exp_pwrite, exp_gid;
    logic [31:0] exp_paddr, exp_pwdata;
    logic [1:0]  exp_rdy, exp_rdy_f;
    bit          done;
    int          errors;
    int          checks;
    int          ncyc;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: per-cycle expectations plus the response scoreboard, sampled on the falling edge.
    initial begin
        rsp_t e;
        errors = 0;
        checks = 0;
        ncyc   = 0;
        forever begin
            @(negedge HCLK);
            ncyc++;
            chk("psel", PSEL, exp_psel);
            chk("penable", PENABLE, exp_pen);
            chk("busy", busy, exp_psel);
            chk("req_ready", req_ready, exp_rdy);
            chk("req_ready_fixed", req_ready_f, exp_rdy_f);
            chk("grant_id", grant_id, exp_gid);
            chk("paddr", PADDR, exp_paddr);
            chk("pwdata", PWDATA, exp_pwdata);
            chk("pwrite", PWRITE, exp_pwrite);
            if (rsp_valid != 2'b00) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected actual=%b required=00", rsp_valid);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_valid", rsp_valid, 64'(2'b01 << e.id));
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
            if (done) begin
                chk("sb_drained", sbq.size(), 0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
            if (ncyc > 3000) begin
                checks++;
                errors++;
                $display("FAIL watchdog actual=%0d required<=3000 cycles", ncyc);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    task automatic step;
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_exp(input logic psel, input logic pen, input logic [1:0] rdy);
        exp_psel  = psel;
        exp_pen   = pen;
        exp_rdy   = rdy;
        exp_rdy_f = rdy;
    endtask

    // One transfer for a lone requester, starting in an IDLE cycle; ends in the response IDLE cycle.
    task automatic xfer(input int id, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input logic err, input bit to);
        rsp_t r;
        req_valid[id]         = 1'b1;
        req_write[id]         = wr;
        req_addr[id*32 +: 32] = addr;
        req_wdata[id*32 +: 32] = wdata;
        set_exp(1'b0, 1'b0, 2'(2'b01 << id));
        r.id    = id;
        r.err   = to ? 1'b1 : err;
        r.rdata = (wr || to) ? 32'h0 : rdata;
        sbq.push_back(r);
        step;
        req_valid[id] = 1'b0;
        set_exp(1'b1, 1'b0, 2'b00);
        exp_paddr  = addr;
        exp_pwdata = wdata;
        exp_pwrite = wr;
        exp_gid    = id[0];
        step;
        for (int i = 0; i < waits; i++) begin
            PREADY = 1'b0;
            set_exp(1'b1, 1'b1, 2'b00);
            step;
        end
        if (!to) begin
            PREADY  = 1'b1;
            PRDATA  = rdata;
            PSLVERR = err;
            set_exp(1'b1, 1'b1, 2'b00);
            step;
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 32'hBAD0_BAD0;
        set_exp(1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        logic [31:0] rr_addr [2];
        rsp_t        r;
        rr_addr[0] = 32'hA000_0000;
        rr_addr[1] = 32'hB000_0004;
        done       = 1'b0;
        HRESETn    = 1'b0;
        req_valid  = 2'b00;
        req_write  = 2'b00;
        req_addr   = '0;
        req_wdata  = '0;
        PRDATA     = 32'hBAD0_BAD0;
        PREADY     = 1'b0;
        PSLVERR    = 1'b0;
        exp_paddr  = '0;
        exp_pwdata = '0;
        exp_pwrite = 1'b0;
        exp_gid    = 1'b0;
        set_exp(1'b0, 1'b0, 2'b00);
        step;
        step;
        HRESETn = 1'b1;
        step;

        // Single write, zero wait states; PRDATA driven nonzero but a write returns 0.
        xfer(0, 1'b1, 32'h1000_0040, 32'hDEADBEEF, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step;
        // Read with 3 wait states; counter reaches TIMEOUT-1 without expiring.
        xfer(1, 1'b0, 32'h2000_0010, 32'h0000_0000, 3, 32'h1234_5678, 1'b0, 1'b0);
        step;
        // Back-to-back: second accept lands in the first response cycle.
        xfer(0, 1'b1, 32'h3000_0000, 32'h0000_0011, 0, 32'h0, 1'b0, 1'b0);
        xfer(1, 1'b1, 32'h3000_0004, 32'h0000_0022, 0, 32'h0, 1'b0, 1'b0);
        step;
        // Slave error on a read with one wait state.
        xfer(0, 1'b0, 32'h4000_0008, 32'h0000_0000, 1, 32'h5555_AAAA, 1'b1, 1'b0);
        step;
        // Timeout after 4 ACCESS cycles; a late PREADY is ignored.
        xfer(1, 1'b0, 32'h5000_000C, 32'h0000_0000, 4, 32'h0, 1'b0, 1'b1);
        PREADY = 1'b1;
        step;
        PREADY = 1'b0;
        step;

        // Reset mid-transfer from requester 0 (pointer now at 0, so reset is what restores 0-first).
        req_valid[0]    = 1'b1;
        req_write[0]    = 1'b1;
        req_addr[31:0]  = 32'h6000_0000;
        req_wdata[31:0] = 32'h0000_0066;
        set_exp(1'b0, 1'b0, 2'b01);
        step;
        req_valid[0] = 1'b0;
        set_exp(1'b1, 1'b0, 2'b00);
        exp_paddr  = 32'h6000_0000;
        exp_pwdata = 32'h0000_0066;
        exp_pwrite = 1'b1;
        exp_gid    = 1'b0;
        step;
        set_exp(1'b1, 1'b1, 2'b00);
        step;
        HRESETn    = 1'b0;
        exp_paddr  = '0;
        exp_pwdata = '0;
        exp_pwrite = 1'b0;
        exp_gid    = 1'b0;
        set_exp(1'b0, 1'b0, 2'b00);
        step;

        // Release with both requesters valid and PREADY high: RR gives 0,1,0,1; fixed gives 0,0,0,0.
        HRESETn   = 1'b1;
        req_valid = 2'b11;
        req_write = 2'b11;
        req_addr  = {rr_addr[1], rr_addr[0]};
        req_wdata = {32'h0000_00B1, 32'h0000_00A0};
        PREADY    = 1'b1;
        for (int g = 0; g < 4; g++) begin
            set_exp(1'b0, 1'b0, 2'(2'b01 << (g % 2)));
            exp_rdy_f = 2'b01;
            r.id    = g % 2;
            r.err   = 1'b0;
            r.rdata = 32'h0;
            sbq.push_back(r);
            step;
            set_exp(1'b1, 1'b0, 2'b00);
            exp_paddr  = rr_addr[g % 2];
            exp_pwdata = (g % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B1;
            exp_pwrite = 1'b1;
            exp_gid    = 1'(g % 2);
            step;
            set_exp(1'b1, 1'b1, 2'b00);
            step;
        end
        req_valid = 2'b00;
        PREADY    = 1'b0;
        set_exp(1'b0, 1'b0, 2'b00);
        step;
        step;
        done = 1'b1;
        step;
        step;
    end

endmodule

// File: doc/apb_req_scheduler.md
Name: apb_req_scheduler

Overview:
- Shares one APB master port between NUM_REQ on-chip requesters using simple valid/ready request and response channels.
- Runs a protocol-correct APB state machine (SETUP, then ACCESS with PREADY wait states) per transfer, with round-robin or fixed-priority arbitration between transfers.
- Adds a bus-hang timeout.
- Sits between the AHB-side front ends and the APB peripheral fabric, and serialises every APB transfer.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority, lowest index wins.
- TIMEOUT, 16, maximum ACCESS cycles before forced error termination; 0 disables the timeout.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester transfer request.
- req_write  in  NUM_REQ  per-requester direction, 1 = write.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data, same slicing.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_rdata  out  DATA_W  read data, shared; valid only with rsp_valid.
- rsp_err  out  1  error flag, valid only with rsp_valid.
- grant_id  out  $clog2(NUM_REQ)  index of the owner of the current or last transfer.
- busy  out  1  high in SETUP or ACCESS.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset values (asynchronous, immediate): state = IDLE; PSEL, PENABLE, PWRITE, busy, rsp_valid, rsp_err = 0; PADDR, PWDATA, rsp_rdata, grant_id = 0; RR pointer = NUM_REQ-1, so requester 0 has top priority first; timeout counter = 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Arbitrate combinationally over req_valid.
  - req_ready[w] = 1 only for winner w, only in IDLE; all other bits 0.
  - On that edge, register PADDR, PWDATA and PWRITE from requester w, set grant_id = w and PSEL = 1, and go to SETUP.
  - No req_valid: stay in IDLE.
- SETUP: PSEL = 1, PENABLE = 0, for exactly one cycle; next state is ACCESS with PENABLE = 1.
- ACCESS:
  - PSEL = PENABLE = 1.
  - PADDR, PWDATA and PWRITE are held stable until completion.
  - Each cycle with PREADY = 0 increments the timeout counter.
- Normal completion: PREADY = 1 sampled at an edge in ACCESS. At that edge:
  - PSEL and PENABLE go to 0, and state returns to IDLE.
  - rsp_valid[grant_id] = 1 for exactly one cycle (the first IDLE cycle).
  - rsp_err = PSLVERR.
  - rsp_rdata = PRDATA on a read, 0 on a write.
- Timeout completion: TIMEOUT ≠ 0 and the counter reaches TIMEOUT with PREADY still 0. At that edge:
  - PSEL and PENABLE drop, and state returns to IDLE.
  - rsp_valid pulses with rsp_err = 1 and rsp_rdata = 0.
  - A PREADY arriving later is ignored.
- Timeout counter: cleared on entry to SETUP; saturates, never wraps.
- Response/accept overlap: the rsp_valid cycle is an IDLE cycle, so a new request may be accepted in the same cycle.
- Throughput: with zero wait states, one transfer per 3 cycles (IDLE, SETUP, ACCESS).
- Round-robin (ARB_MODE = 0):
  - Search starts at pointer+1 mod NUM_REQ and takes the first asserted req_valid.
  - On accept, pointer = winner.
  - Wrap from NUM_REQ-1 to 0.
- Fixed priority (ARB_MODE = 1): lowest asserted index wins; the pointer is unused.
- Requester obligations: req_* must stay stable while req_valid = 1 and req_ready = 0. Deasserting req_valid before accept is legal and is simply not granted. A requester may not issue a new request before receiving its rsp_valid (protocol rule; not checked).
- Inputs sampled: PRDATA and PSLVERR only in ACCESS with PREADY = 1. PREADY is ignored in IDLE and SETUP.
- Reset mid-transfer: the APB bus returns to idle immediately. No rsp_valid is issued for the aborted transfer, and arbitration restarts from requester 0.
- grant_id holds its value after completion until the next accept.

Test Plan:
- Single write, zero wait: req 0 valid, addr 0x1000_0040, wdata 0xDEADBEEF → req_ready[0] in cycle 0; SETUP in cycle 1 (PSEL = 1, PENABLE = 0); ACCESS in cycle 2; rsp_valid[0] = 1 with rsp_err = 0 in cycle 3.
- Read with 3 wait states: PREADY low 3 ACCESS cycles, then PRDATA = 0x1234_5678 → PADDR stable throughout; rsp_rdata = 0x1234_5678 with rsp_valid[1].
- RR fairness, NUM_REQ = 2: both requesters valid continuously for 4 transfers → grant order 0, 1, 0, 1. With ARB_MODE = 1, order is 0, 0, 0, 0.
- Error and timeout, TIMEOUT = 4: PSLVERR = 1 with PREADY → rsp_err = 1. A transfer with PREADY held 0 → termination after 4 ACCESS cycles with rsp_err = 1 and rsp_rdata = 0.
- Back-to-back overlap: req 1 waiting while req 0 completes → rsp_valid[0] and req_ready[1] high in the same cycle.
- Reset mid-transfer: HRESETn low during ACCESS → PSEL = PENABLE = 0 immediately, no rsp_valid. After release with both requesters valid, requester 0 is granted first.
